avl_frame_reader: RTL and testbench

AVL_FRAME_READER -- requirements
Module: avl_frame_reader

---
 rtl/avl_frame_reader.sv | 134 +++++++++++++
 tb/tb_avl_frame_reader.sv | 587 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_frame_reader.sv
// Avalon-MM frame reader that streams FRAME_WORDS words from BASE_ADDR through a show-ahead FIFO.
// The optional popped-word checksum is built only when FRAME_READER_CHECKSUM_EN is defined.
module avl_frame_reader #(
    parameter int          ADDR_W      = 27,
    parameter int          DATA_W      = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          FRAME_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_burstbegin,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic [DATA_W-1:0] oPIX_DATA,
    output logic              oPIX_VALID,
    input  logic              iPIX_READY,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [31:0]       oCHECKSUM
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [IW-1:0]     LAST  = IW'(FRAME_WORDS - 1);
    localparam logic [CW:0]       DEPTH = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic start, room, accept, push, pop;

    assign start = (state_q == IDLE) && iSTART && local_init_done;
    // Counting in-flight reads against free space guarantees the FIFO never overflows.
    assign room  = ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH;

    assign avl_read       = (state_q == REQ) && room;
    assign avl_burstbegin = avl_read;
    assign avl_address    = addr_q;

    assign accept = avl_read && avl_waitrequest_n;
    assign push   = avl_readdatavalid && (out_q != '0);

    assign oPIX_VALID = (cnt_q != '0);
    assign pop        = oPIX_VALID && iPIX_READY;
    assign oPIX_DATA  = oPIX_VALID ? mem[rd_q] : '0;
    assign oBUSY      = (state_q != IDLE);
    assign oDONE      = (state_q == FIN);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        out_d    = out_q + CW'(accept) - CW'(push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_d     = push ? wr_q + AW'(1) : wr_q;
        rd_d     = pop ? rd_q + AW'(1) : rd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = REQ;
                    addr_d   = BASE;
                    issued_d = '0;
                    out_d    = '0;
                end
            end
            REQ: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + IW'(1);
                    if (issued_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0 && cnt_q == '0) state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q  <= IDLE;
            addr_q   <= BASE;
            issued_q <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) mem[wr_q] <= avl_readdata;
    end

`ifdef FRAME_READER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge iCLK) begin
        if (!iRST_n)    sum_q <= '0;
        else if (start) sum_q <= '0;
        else if (pop)   sum_q <= sum_q + 32'(oPIX_DATA);
    end

    assign oCHECKSUM = sum_q;
`else
    assign oCHECKSUM = '0;
`endif

endmodule

// File: tb/tb_avl_frame_reader.sv
// Randomized self-checking bench for avl_frame_reader: three instances share one memory model
// selected by sel; expected addresses, data and checksums come from plain arithmetic.
module tb_avl_frame_reader;

    localparam int unsigned B0 = 32'h100;
    localparam int unsigned B1 = 32'h7FFFFFE;
    localparam int unsigned B2 = 32'h200;
    localparam int F0 = 8;
    localparam int F1 = 4;
    localparam int F2 = 40;

    typedef struct packed {
        int          due;
        logic [31:0] d;
    } ret_t;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        start [3];
    logic        wrn   [3];
    logic [26:0] addr  [3];
    logic        rd    [3];
    logic        bb    [3];
    logic        rdv   [3];
    logic [31:0] rdat  [3];
    logic [31:0] pdat  [3];
    logic        pval  [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [31:0] cks   [3];

    int sel;
    int cyc;
    int vectors;
    int miscompares;
    int wr_hold;
    int stray;
    bit wr_rand;
    bit rdy_rand;

    logic [26:0] acc_q [$];
    logic [31:0] pix_q [$];
    ret_t        pend  [$];
    int          done_cnt;
    int          hold_cnt;
    int          hold_err;
    int          bb_err;
    int          first_rdv;
    int          first_val;
    bit          hold_pend;
    logic [26:0] hold_addr;

    avl_frame_reader #(.BASE_ADDR(B0), .FRAME_WORDS(F0)) u_a (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start[0]),
        .local_init_done(init_done), .avl_waitrequest_n(wrn[0]),
        .avl_address(addr[0]), .avl_read(rd[0]), .avl_burstbegin(bb[0]),
        .avl_readdatavalid(rdv[0]), .avl_readdata(rdat[0]),
        .oPIX_DATA(pdat[0]), .oPIX_VALID(pval[0]), .iPIX_READY(rdy[0]),
        .oBUSY(busy[0]), .oDONE(done[0]), .oCHECKSUM(cks[0])
    );

    avl_frame_reader #(.BASE_ADDR(B1), .FRAME_WORDS(F1)) u_w (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start[1]),
        .local_init_done(init_done), .avl_waitrequest_n(wrn[1]),
        .avl_address(addr[1]), .avl_read(rd[1]), .avl_burstbegin(bb[1]),
        .avl_readdatavalid(rdv[1]), .avl_readdata(rdat[1]),
        .oPIX_DATA(pdat[1]), .oPIX_VALID(pval[1]), .iPIX_READY(rdy[1]),
        .oBUSY(busy[1]), .oDONE(done[1]), .oCHECKSUM(cks[1])
    );

    avl_frame_reader #(.BASE_ADDR(B2), .FRAME_WORDS(F2)) u_b (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start[2]),
        .local_init_done(init_done), .avl_waitrequest_n(wrn[2]),
        .avl_address(addr[2]), .avl_read(rd[2]), .avl_burstbegin(bb[2]),
        .avl_readdatavalid(rdv[2]), .avl_readdata(rdat[2]),
        .oPIX_DATA(pdat[2]), .oPIX_VALID(pval[2]), .iPIX_READY(rdy[2]),
        .oBUSY(busy[2]), .oDONE(done[2]), .oCHECKSUM(cks[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int unsigned base_of(int s);
        if (s == 0) return B0;
        if (s == 1) return B1;
        return B2;
    endfunction

    function automatic int fw_of(int s);
        if (s == 0) return F0;
        if (s == 1) return F1;
        return F2;
    endfunction

    function automatic logic [26:0] exp_addr(int s, int i);
        int unsigned a;
        a = base_of(s) + i;
        return a[26:0];
    endfunction

    function automatic logic [31:0] exp_sum(int s);
        logic [31:0] acc;
        acc = '0;
`ifdef FRAME_READER_CHECKSUM_EN
        for (int i = 0; i < fw_of(s); i++) acc = acc + 32'(exp_addr(s, i));
`endif
        return acc;
    endfunction

    // Memory model (word = address, return 3 cycles after acceptance) and bus monitor.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (i != sel) begin
                    wrn[i]  = 1'b1;
                    rdv[i]  = 1'b0;
                    rdat[i] = '0;
                end
            end
            if (rdy_rand) rdy[sel] = 1'($urandom_range(0, 1));
            if (wr_hold > 0 && rd[sel]) begin
                wrn[sel] = 1'b0;
                wr_hold--;
            end else if (wr_rand) begin
                wrn[sel] = ($urandom_range(0, 3) != 0);
            end else begin
                wrn[sel] = 1'b1;
            end
            if (stray > 0) begin
                rdv[sel]  = 1'b1;
                rdat[sel] = $urandom;
                stray--;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                rdv[sel]  = 1'b1;
                rdat[sel] = pend[0].d;
                void'(pend.pop_front());
            end else begin
                rdv[sel]  = 1'b0;
                rdat[sel] = $urandom;
            end
            #3;
            if (rst_n) begin
                if (rd[sel] && wrn[sel]) begin
                    acc_q.push_back(addr[sel]);
                    pend.push_back('{cyc + 3, 32'(addr[sel])});
                end
                if (pval[sel] && rdy[sel]) pix_q.push_back(pdat[sel]);
                if (done[sel]) done_cnt++;
                if (rd[sel] && !wrn[sel]) hold_cnt++;
                if (rdv[sel] && first_rdv < 0) first_rdv = cyc;
                if (pval[sel] && first_val < 0) first_val = cyc;
                if (hold_pend && !(rd[sel] && addr[sel] === hold_addr)) hold_err++;
                hold_pend = rd[sel] && !wrn[sel];
                hold_addr = addr[sel];
            end else begin
                hold_pend = 1'b0;
            end
            if (bb[sel] !== rd[sel]) bb_err++;
        end
    end

    task automatic clear_logs();
        acc_q.delete();
        pix_q.delete();
        done_cnt  = 0;
        hold_cnt  = 0;
        hold_err  = 0;
        bb_err    = 0;
        first_rdv = -1;
        first_val = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        int base;
        base = done_cnt;
        ok = 1'b0;
        repeat (max) begin
            @(negedge clk);
            #4;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        vectors++;
        if (rd[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_read: got %b want 0", rd[0]);
        end
        vectors++;
        if (bb[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_burst: got %b want 0", bb[0]);
        end
        vectors++;
        if (addr[0] !== 27'(B0)) begin
            miscompares++; $display("FAIL rst_addr: got %h want %h", addr[0], B0);
        end
        vectors++;
        if (addr[1] !== 27'(B1)) begin
            miscompares++; $display("FAIL rst_addr_w: got %h want %h", addr[1], B1);
        end
        vectors++;
        if (pval[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_pval: got %b want 0", pval[0]);
        end
        vectors++;
        if (pdat[0] !== 32'h0) begin
            miscompares++; $display("FAIL rst_pdat: got %h want 0", pdat[0]);
        end
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_busy: got %b want 0", busy[0]);
        end
        vectors++;
        if (done[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_done: got %b want 0", done[0]);
        end
        vectors++;
        if (cks[0] !== 32'h0) begin
            miscompares++; $display("FAIL rst_cks: got %h want 0", cks[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        sel = 0;
        clear_logs();
        pulse_start();
        wait_done(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL basic_timeout: got no done want done");
        end
        repeat (5) @(negedge clk);
        #4;
        vectors++;
        if (acc_q.size() != F0) begin
            miscompares++; $display("FAIL basic_nreads: got %0d want %0d", acc_q.size(), F0);
        end
        for (int i = 0; i < F0; i++) begin
            vectors++;
            if (i >= acc_q.size() || acc_q[i] !== exp_addr(0, i)) begin
                miscompares++; $display("FAIL basic_addr[%0d]: got %h want %h", i,
                                        (i < acc_q.size()) ? acc_q[i] : 27'hx, exp_addr(0, i));
            end
            vectors++;
            if (i >= pix_q.size() || pix_q[i] !== 32'(exp_addr(0, i))) begin
                miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", i,
                                        (i < pix_q.size()) ? pix_q[i] : 32'hx, exp_addr(0, i));
            end
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
        end
        vectors++;
        if (cks[0] !== exp_sum(0)) begin
            miscompares++; $display("FAIL basic_cks: got %h want %h", cks[0], exp_sum(0));
        end
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++; $display("FAIL basic_busy: got %b want 0", busy[0]);
        end
        vectors++;
        if (first_val - first_rdv != 1) begin
            miscompares++; $display("FAIL basic_showahead: got %0d cycles want 1",
                                    first_val - first_rdv);
        end
        vectors++;
        if (bb_err != 0) begin
            miscompares++; $display("FAIL basic_burstbegin: got %0d diffs want 0", bb_err);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        sel = 2;
        rdy[2] = 1'b0;
        clear_logs();
        pulse_start();
        repeat (60) @(negedge clk);
        #4;
        vectors++;
        if (acc_q.size() != 16) begin
            miscompares++; $display("FAIL bp_nreads: got %0d want 16", acc_q.size());
        end
        vectors++;
        if (rd[2] !== 1'b0) begin
            miscompares++; $display("FAIL bp_read_low: got %b want 0", rd[2]);
        end
        vectors++;
        if (pval[2] !== 1'b1) begin
            miscompares++; $display("FAIL bp_pval: got %b want 1", pval[2]);
        end
        @(negedge clk);
        rdy[2] = 1'b1;
        wait_done(400, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL bp_timeout: got no done want done");
        end
        repeat (3) @(negedge clk);
        #4;
        vectors++;
        if (pix_q.size() != F2) begin
            miscompares++; $display("FAIL bp_nwords: got %0d want %0d", pix_q.size(), F2);
        end
        for (int i = 0; i < F2; i++) begin
            vectors++;
            if (i >= acc_q.size() || acc_q[i] !== exp_addr(2, i)) begin
                miscompares++; $display("FAIL bp_addr[%0d]: got %h want %h", i,
                                        (i < acc_q.size()) ? acc_q[i] : 27'hx, exp_addr(2, i));
            end
            vectors++;
            if (i >= pix_q.size() || pix_q[i] !== 32'(exp_addr(2, i))) begin
                miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i,
                                        (i < pix_q.size()) ? pix_q[i] : 32'hx, exp_addr(2, i));
            end
        end
        vectors++;
        if (cks[2] !== exp_sum(2)) begin
            miscompares++; $display("FAIL bp_cks: got %h want %h", cks[2], exp_sum(2));
        end
    endtask

    task automatic test_waitrequest();
        bit ok;
        sel = 0;
        clear_logs();
        wr_hold = 5;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            #4;
            vectors++;
            if (rd[0] !== 1'b1 || addr[0] !== 27'(B0) || wrn[0] !== (k == 5)) begin
                miscompares++; $display("FAIL wr_hold[%0d]: got rd=%b a=%h wrn=%b want rd=1 a=%h",
                                        k, rd[0], addr[0], wrn[0], B0);
            end
            @(negedge clk);
        end
        wait_done(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL wr_timeout: got no done want done");
        end
        vectors++;
        if (hold_cnt != 5) begin
            miscompares++; $display("FAIL wr_holdcnt: got %0d want 5", hold_cnt);
        end
        vectors++;
        if (acc_q.size() != F0 || acc_q[0] !== 27'(B0)) begin
            miscompares++; $display("FAIL wr_reads: got n=%0d want %0d from %h",
                                    acc_q.size(), F0, B0);
        end
        vectors++;
        if (hold_err != 0) begin
            miscompares++; $display("FAIL wr_stable: got %0d changes want 0", hold_err);
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        sel = 0;
        clear_logs();
        init_done = 1'b0;
        pulse_start();
        repeat (10) @(negedge clk);
        #4;
        vectors++;
        if (busy[0] !== 1'b0 || acc_q.size() != 0) begin
            miscompares++; $display("FAIL ign_uncal: got busy=%b n=%0d want 0 0",
                                    busy[0], acc_q.size());
        end
        @(negedge clk);
        init_done = 1'b1;
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_done(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL ign_timeout: got no done want done");
        end
        repeat (30) @(negedge clk);
        #4;
        vectors++;
        if (done_cnt != 1 || acc_q.size() != F0 || busy[0] !== 1'b0) begin
            miscompares++; $display("FAIL ign_extra: got done=%0d n=%0d busy=%b want 1 %0d 0",
                                    done_cnt, acc_q.size(), F0, busy[0]);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit hit;
        sel = 0;
        clear_logs();
        pulse_start();
        hit = 1'b0;
        repeat (50) begin
            #4;
            if (acc_q.size() >= 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!hit) begin
            miscompares++; $display("FAIL mid_timeout: got %0d reads want 3", acc_q.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        vectors++;
        if (acc_q.size() != 3) begin
            miscompares++; $display("FAIL mid_naccepted: got %0d want 3", acc_q.size());
        end
        vectors++;
        if (rd[0] !== 1'b0 || bb[0] !== 1'b0 || addr[0] !== 27'(B0) || pval[0] !== 1'b0 ||
            pdat[0] !== 32'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || cks[0] !== 32'h0) begin
            miscompares++; $display("FAIL mid_rstvals: got rd=%b a=%h pv=%b pd=%h busy=%b cks=%h",
                                    rd[0], addr[0], pval[0], pdat[0], busy[0], cks[0]);
        end
        pix_q.delete();
        @(negedge clk);
        stray = 2;
        repeat (12) @(negedge clk);
        #4;
        vectors++;
        if (pval[0] !== 1'b0 || pix_q.size() != 0 || busy[0] !== 1'b0) begin
            miscompares++; $display("FAIL mid_stray: got pv=%b n=%0d busy=%b want 0 0 0",
                                    pval[0], pix_q.size(), busy[0]);
        end
        clear_logs();
        pulse_start();
        wait_done(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL mid_timeout2: got no done want done");
        end
        repeat (3) @(negedge clk);
        #4;
        for (int i = 0; i < F0; i++) begin
            vectors++;
            if (i >= pix_q.size() || pix_q[i] !== 32'(exp_addr(0, i))) begin
                miscompares++; $display("FAIL mid_data[%0d]: got %h want %h", i,
                                        (i < pix_q.size()) ? pix_q[i] : 32'hx, exp_addr(0, i));
            end
        end
        vectors++;
        if (cks[0] !== exp_sum(0) || done_cnt != 1) begin
            miscompares++; $display("FAIL mid_final: got cks=%h done=%0d want %h 1",
                                    cks[0], done_cnt, exp_sum(0));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        sel = 1;
        clear_logs();
        pulse_start();
        wait_done(100, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL wrap_timeout: got no done want done");
        end
        repeat (3) @(negedge clk);
        #4;
        vectors++;
        if (acc_q.size() != F1) begin
            miscompares++; $display("FAIL wrap_nreads: got %0d want %0d", acc_q.size(), F1);
        end
        for (int i = 0; i < F1; i++) begin
            vectors++;
            if (i >= acc_q.size() || acc_q[i] !== exp_addr(1, i)) begin
                miscompares++; $display("FAIL wrap_addr[%0d]: got %h want %h", i,
                                        (i < acc_q.size()) ? acc_q[i] : 27'hx, exp_addr(1, i));
            end
        end
        vectors++;
        if (cks[1] !== exp_sum(1)) begin
            miscompares++; $display("FAIL wrap_cks: got %h want %h", cks[1], exp_sum(1));
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int f = 0; f < 4; f++) begin
            sel = f % 3;
            clear_logs();
            wr_rand  = 1'b1;
            rdy_rand = 1'b1;
            pulse_start();
            wait_done(3000, ok);
            @(negedge clk);
            wr_rand  = 1'b0;
            rdy_rand = 1'b0;
            rdy[sel] = 1'b1;
            repeat (3) @(negedge clk);
            #4;
            vectors++;
            if (!ok || done_cnt != 1) begin
                miscompares++; $display("FAIL rnd%0d_done: got ok=%b pulses=%0d want 1 1",
                                        f, ok, done_cnt);
            end
            vectors++;
            if (acc_q.size() != fw_of(sel) || pix_q.size() != fw_of(sel)) begin
                miscompares++; $display("FAIL rnd%0d_count: got %0d/%0d want %0d",
                                        f, acc_q.size(), pix_q.size(), fw_of(sel));
            end
            for (int i = 0; i < fw_of(sel); i++) begin
                vectors++;
                if (i >= pix_q.size() || pix_q[i] !== 32'(exp_addr(sel, i))) begin
                    miscompares++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", f, i,
                                            (i < pix_q.size()) ? pix_q[i] : 32'hx,
                                            exp_addr(sel, i));
                end
            end
            vectors++;
            if (cks[sel] !== exp_sum(sel)) begin
                miscompares++; $display("FAIL rnd%0d_cks: got %h want %h",
                                        f, cks[sel], exp_sum(sel));
            end
            vectors++;
            if (hold_err != 0 || bb_err != 0) begin
                miscompares++; $display("FAIL rnd%0d_bus: got hold=%0d bb=%0d want 0 0",
                                        f, hold_err, bb_err);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 0;
        wr_hold     = 0;
        stray       = 0;
        wr_rand     = 1'b0;
        rdy_rand    = 1'b0;
        init_done   = 1'b1;
        hold_pend   = 1'b0;
        hold_addr   = '0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            wrn[i]   = 1'b1;
            rdv[i]   = 1'b0;
            rdat[i]  = '0;
            rdy[i]   = 1'b1;
        end
        clear_logs();
        test_reset();
        test_basic();
        test_backpressure();
        test_waitrequest();
        test_ignored_start();
        test_reset_midframe();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
